// File: rtl/shift_compute_sequencer_if.sv
// rtl/shift_compute_sequencer_if.sv - request/result handshake bundle for the shift/ALU tile sequencer
interface shift_compute_sequencer_if;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [1:0] op_code;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output op_a, op_b, op_code, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  op_a, op_b, op_code, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/shift_compute_sequencer.sv
// rtl/shift_compute_sequencer.sv - serialises an operand pair into the shift/ALU tile and returns its result byte
module shift_compute_sequencer #(
    parameter int SETTLE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    shift_compute_sequencer_if.slave   bus,
    output logic                       ser_data,
    output logic                       cap_add,
    output logic                       cap_and,
    output logic [1:0]                 sel,
    input  logic [7:0]                 res_in,
    output logic                       busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SETTLE  = 3'd3;
    localparam logic [2:0] S_SAMPLE  = 3'd4;

    // With no settle padding the tile result is sampled straight after capture/shift.
    localparam logic [2:0] S_POST = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
    localparam int         SW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] OP_ADD    = 2'd0;
    localparam logic [1:0] OP_AND    = 2'd1;
    localparam logic [1:0] OP_READ_B = 2'd2;

    logic [2:0]    state;
    logic [3:0]    cnt;
    logic [15:0]   data;
    logic [1:0]    op;
    logic [SW-1:0] settle_cnt;
    logic          out_valid_r;
    logic [7:0]    out_data_r;
    logic [1:0]    op_sel;

    assign bus.in_ready  = (state == S_IDLE) && !out_valid_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            data        <= 16'd0;
            op          <= 2'd0;
            settle_cnt  <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
        end else begin
            if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        data  <= {bus.op_a, bus.op_b};
                        op    <= bus.op_code;
                        cnt   <= 4'd0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        settle_cnt <= '0;
                        // Raw reads must not see an extra clock, so they skip capture.
                        state      <= op[1] ? S_POST : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    settle_cnt <= '0;
                    state      <= S_POST;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + SW'(1);
                    if (settle_cnt == SW'(SETTLE - 1)) begin
                        state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    out_data_r  <= res_in;
                    out_valid_r <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        op_sel = 2'b00;
        case (op)
            OP_ADD:    op_sel = 2'b10;
            OP_AND:    op_sel = 2'b11;
            OP_READ_B: op_sel = 2'b00;
            default:   op_sel = 2'b01;
        endcase
    end

    assign ser_data = (state == S_SHIFT) ? data[4'd15 - cnt] : 1'b0;
    assign cap_add  = (state == S_CAPTURE) && (op == OP_ADD);
    assign cap_and  = (state == S_CAPTURE) && (op == OP_AND);
    assign sel      = (state == S_CAPTURE || state == S_SETTLE || state == S_SAMPLE) ? op_sel : 2'b00;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_shift_compute_sequencer.sv
// tb/tb_shift_compute_sequencer.sv - randomized and directed checks of the sequencer driving a behavioural tile
module tb_shift_compute_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_compute_sequencer_if bus0();
    shift_compute_sequencer_if bus1();

    logic       ser0, cadd0, cand0, bsy0, ser1, cadd1, cand1, bsy1;
    logic [1:0] sel0, sel1;
    logic [7:0] res0, res1;

    shift_compute_sequencer #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .ser_data(ser0), .cap_add(cadd0),
        .cap_and(cand0), .sel(sel0), .res_in(res0), .busy(bsy0)
    );
    shift_compute_sequencer #(.SETTLE(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .ser_data(ser1), .cap_add(cadd1),
        .cap_and(cand1), .sel(sel1), .res_in(res1), .busy(bsy1)
    );

    // Behavioural tiles: shift every clock, capture on strobe, result muxed by sel.
    logic [15:0] sh0 = '0, sh1 = '0;
    logic [7:0]  add0 = '0, and0 = '0, add1 = '0, and1 = '0;
    always @(posedge clk) begin
        sh0 <= {sh0[14:0], ser0};
        sh1 <= {sh1[14:0], ser1};
        if (cadd0) add0 <= sh0[15:8] + sh0[7:0];
        if (cand0) and0 <= sh0[15:8] & sh0[7:0];
        if (cadd1) add1 <= sh1[15:8] + sh1[7:0];
        if (cand1) and1 <= sh1[15:8] & sh1[7:0];
    end

    function automatic logic [7:0] tile_res(input logic [1:0] s, input logic [15:0] sh,
                                            input logic [7:0] ad, input logic [7:0] an);
        case (s)
            2'b00:   return sh[7:0];
            2'b01:   return sh[15:8];
            2'b10:   return ad;
            default: return an;
        endcase
    endfunction
    assign res0 = tile_res(sel0, sh0, add0, and0);
    assign res1 = tile_res(sel1, sh1, add1, and1);

    int cur = 0;
    logic       ser, cadd, cand, vld, rdy, bsy;
    logic [1:0] sl;
    logic [7:0] od;
    always_comb begin
        ser  = (cur == 1) ? ser1 : ser0;
        cadd = (cur == 1) ? cadd1 : cadd0;
        cand = (cur == 1) ? cand1 : cand0;
        bsy  = (cur == 1) ? bsy1 : bsy0;
        sl   = (cur == 1) ? sel1 : sel0;
        vld  = (cur == 1) ? bus1.out_valid : bus0.out_valid;
        rdy  = (cur == 1) ? bus1.in_ready : bus0.in_ready;
        od   = (cur == 1) ? bus1.out_data : bus0.out_data;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_result(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c);
        case (c)
            2'd0:    return 8'((a + b) % 256);
            2'd1:    return a & b;
            2'd2:    return b;
            default: return a;
        endcase
    endfunction

    function automatic logic [1:0] ref_sel(input logic [1:0] c);
        case (c)
            2'd0:    return 2'b10;
            2'd1:    return 2'b11;
            2'd2:    return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    task automatic drive_req(input int u, input logic [7:0] a, input logic [7:0] b,
                             input logic [1:0] c, input logic v);
        if (u == 1) begin
            bus1.op_a = a; bus1.op_b = b; bus1.op_code = c; bus1.in_valid = v;
        end else begin
            bus0.op_a = a; bus0.op_b = b; bus0.op_code = c; bus0.in_valid = v;
        end
    endtask

    task automatic set_out_ready(input int u, input logic v);
        if (u == 1) bus1.out_ready = v;
        else        bus0.out_ready = v;
    endtask

    task automatic do_op(input int u, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] c, input int hold);
        int lat = -1, cap_add_n = 0, cap_and_n = 0, cap_pos = -1;
        int ser_err = 0, sel_err = 0, busy_err = 0, hold_err = 0;
        int settle = (u == 1) ? 3 : 0;
        logic [15:0] word = {a, b};
        logic [7:0]  held;
        logic [1:0]  exp_sel;
        @(negedge clk);
        cur = u;
        #1;
        check("in_ready_idle", rdy, 1'b1);
        drive_req(u, a, b, c, 1'b1);
        @(posedge clk);
        #1;
        drive_req(u, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0);
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if (vld) begin
                lat = k;
            end else begin
                if (k < 16 && ser !== word[15 - k]) ser_err++;
                if (k >= 16 && ser !== 1'b0) ser_err++;
                exp_sel = (k < 16) ? 2'b00 : ref_sel(c);
                if (sl !== exp_sel) sel_err++;
                if (bsy !== 1'b1 || rdy !== 1'b0) busy_err++;
                if (cadd) begin cap_add_n++; cap_pos = k; end
                if (cand) begin cap_and_n++; cap_pos = k; end
                drive_req(u, 8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));
            end
        end
        drive_req(u, 8'h00, 8'h00, 2'd0, 1'b0);
        check("latency", lat, ((c < 2) ? 18 : 17) + settle);
        check("result", od, ref_result(a, b, c));
        check("ser_bits", ser_err, 0);
        check("sel_seq", sel_err, 0);
        check("busy_inrdy", busy_err, 0);
        check("cap_add_n", cap_add_n, (c == 2'd0) ? 1 : 0);
        check("cap_and_n", cap_and_n, (c == 2'd1) ? 1 : 0);
        check("cap_pos", cap_pos, (c < 2) ? 16 : -1);
        held = od;
        for (int h = 0; h < hold; h++) begin
            drive_req(u, 8'($urandom), 8'($urandom), 2'($urandom), 1'b1);
            @(negedge clk);
            if (vld !== 1'b1 || od !== held || rdy !== 1'b0 || bsy !== 1'b0) hold_err++;
        end
        drive_req(u, 8'h00, 8'h00, 2'd0, 1'b0);
        if (hold > 0) check("hold_stable", hold_err, 0);
        set_out_ready(u, 1'b1);
        @(negedge clk);
        set_out_ready(u, 1'b0);
        check("consumed_valid", vld, 1'b0);
        check("consumed_ready", rdy, 1'b1);
    endtask

    initial begin
        drive_req(0, 8'h00, 8'h00, 2'd0, 1'b0);
        drive_req(1, 8'h00, 8'h00, 2'd0, 1'b0);
        set_out_ready(0, 1'b0);
        set_out_ready(1, 1'b0);
        #3;
        check("rst_busy", bsy0, 1'b0);
        check("rst_valid", bus0.out_valid, 1'b0);
        check("rst_data", bus0.out_data, 8'h00);
        check("rst_outs", {ser0, cadd0, cand0, sel0}, 5'b0);
        check("rst_in_ready", bus0.in_ready, 1'b1);
        check("rst_busy1", bsy1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 8'h5A, 8'hC3, 2'd0, 0);
        do_op(0, 8'hF0, 8'h3C, 2'd1, 0);
        do_op(0, 8'hA5, 8'h00, 2'd3, 0);
        do_op(0, 8'h11, 8'h7E, 2'd2, 0);
        do_op(0, 8'h81, 8'h42, 2'd0, 5);
        do_op(0, 8'hFF, 8'hFF, 2'd0, 1);

        // Abort an ADD partway through shifting, then prove a fresh op is clean.
        @(negedge clk);
        cur = 0;
        drive_req(0, 8'h33, 8'h44, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        drive_req(0, 8'h00, 8'h00, 2'd0, 1'b0);
        repeat (8) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", bsy0, 1'b0);
        check("abort_outs", {ser0, cadd0, cand0, sel0}, 5'b0);
        check("abort_valid", bus0.out_valid, 1'b0);
        check("abort_data", bus0.out_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 8'h01, 8'h01, 2'd0, 0);

        for (int i = 0; i < 20; i++) begin
            do_op(0, 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end

        do_op(1, 8'hFF, 8'h01, 2'd0, 0);
        for (int i = 0; i < 4; i++) begin
            do_op(1, 8'($urandom), 8'($urandom), 2'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
